// File: rtl/mem_stage_pkg.sv
// Shared op codes, FSM state encoding and op-class predicates for the MEM stage.
package mem_stage_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Stores narrower than a word need a read-modify-write.
  function automatic logic is_subword(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_stage_ls_lane_align.sv
// Combinational little-endian lane logic: load extraction/extension and store merge.
module ls_lane_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_result,
  output logic [31:0] o_merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load_result = i_word;
    case (i_op)
      OP_LB:   o_load_result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_result = {24'h000000, w_byte};
      OP_LH:   o_load_result = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_result = {16'h0000, w_half};
      default: o_load_result = i_word;
    endcase
  end

  always_comb begin
    o_merged_word = i_word;
    if (i_op == OP_SB) begin
      case (i_addr_lo)
        2'd0:    o_merged_word[7:0]   = i_store_data[7:0];
        2'd1:    o_merged_word[15:8]  = i_store_data[7:0];
        2'd2:    o_merged_word[23:16] = i_store_data[7:0];
        default: o_merged_word[31:24] = i_store_data[7:0];
      endcase
    end else if (i_op == OP_SH) begin
      if (i_addr_lo[1]) o_merged_word[31:16] = i_store_data[15:0];
      else              o_merged_word[15:0]  = i_store_data[15:0];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: loads, word stores, and 2-cycle RMW for byte/half stores.
// Optional MEM_MISALIGN_TRAP_EN suppresses misaligned half/word accesses and reports them.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_rd,
  output logic              stall_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_exc,
  output logic [ADDR_W-1:0] misalign_addr
`endif
);

  state_t            r_state;
  logic [DATA_W-1:0] r_merge_q;
  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [DATA_W-1:0] r_wb_data;
  logic [REG_W-1:0]  r_wb_rd;
  logic [DATA_W-1:0] w_load_result;
  logic [DATA_W-1:0] w_merged_word;
  logic              w_trap;
  logic              w_idle;

  ls_lane_align u_lane (
    .i_op          (in_op),
    .i_addr_lo     (in_addr[1:0]),
    .i_word        (mem_read_data),
    .i_store_data  (in_store_data),
    .o_load_result (w_load_result),
    .o_merged_word (w_merged_word)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic              r_misalign_exc;
  logic [ADDR_W-1:0] r_misalign_addr;
  assign w_trap = in_valid && ((is_half(in_op) && in_addr[0]) ||
                               (is_word(in_op) && (in_addr[1:0] != 2'b00)));
  assign misalign_exc  = r_misalign_exc;
  assign misalign_addr = r_misalign_addr;
`else
  assign w_trap = 1'b0;
`endif

  assign w_idle         = (r_state == IDLE);
  assign mem_addr       = in_addr;
  assign stall_out      = w_idle && in_valid && is_subword(in_op) && !w_trap;
  assign mem_write_data = w_idle ? in_store_data : r_merge_q;
  // Gated by reset so an in-flight RMW write drops immediately.
  assign mem_write      = !reset && (!w_idle ||
                                     (in_valid && (in_op == OP_SW) && !w_trap));

  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_merge_q      <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_data      <= '0;
      r_wb_rd        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign_exc  <= 1'b0;
      r_misalign_addr <= '0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      r_misalign_exc <= 1'b0;
      if (w_idle && w_trap) begin
        r_misalign_exc  <= 1'b1;
        r_misalign_addr <= in_addr;
      end
`endif
      case (r_state)
        WRITE: begin
          r_state        <= IDLE;
          r_wb_valid     <= 1'b1;
          r_wb_reg_write <= 1'b0;
        end
        default: begin
          if (in_valid && w_trap) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= 1'b0;
          end else if (in_valid && is_subword(in_op)) begin
            // Stall cycle: capture merged word, retire from WRITE next cycle.
            r_merge_q      <= w_merged_word;
            r_state        <= WRITE;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
          end else if (in_valid && is_load(in_op)) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= (in_rd != '0);
            r_wb_data      <= w_load_result;
            r_wb_rd        <= in_rd;
          end else begin
            r_wb_valid     <= in_valid;
            r_wb_reg_write <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a small word memory model.
// Build with MEM_MISALIGN_TRAP_EN defined to exercise the misalignment trap.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        stall_out;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_exc;
  logic [31:0] misalign_addr;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = 32'h0;
  logic [31:0] pre_data = 32'h0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_op          (in_op),
    .in_addr        (in_addr),
    .in_store_data  (in_store_data),
    .in_rd          (in_rd),
    .stall_out      (stall_out),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_data        (wb_data),
    .wb_rd          (wb_rd)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr)
`endif
  );

  assign mem_read_data = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[11:2]] <= mem_write_data;
    else if (pre_en) mem[pre_addr[11:2]] <= pre_data;
  end

  // Upstream must keep the store valid while the RMW write is in progress.
  always @(negedge clk) begin
    if (!reset && mem_write && !in_valid) begin
      errors++;
      $error("FAIL protocol mem_write with in_valid=0 at %0t", $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    in_valid = v; in_op = op; in_addr = a; in_store_data = d; in_rd = rd;
    $display("txn valid=%0d op=%0d addr=%h data=%h rd=%0d", v, op, a, d, rd);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 5'd0);
    tick();
    preload(32'h100, 32'h8899AABB);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    check("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Loads over word 0x8899AABB
    drive(1'b1, OP_LB, 32'h103, 32'h0, 5'd5);
    @(negedge clk);
    check("lb_stall", {31'b0, stall_out}, 32'h0);
    check("lb_mem_addr", mem_addr, 32'h103);
    tick();
    check("lb_wb_valid", {31'b0, wb_valid}, 32'h1);
    check("lb_wb_reg_write", {31'b0, wb_reg_write}, 32'h1);
    check("lb_wb_data", wb_data, 32'hFFFFFF88);
    check("lb_wb_rd", {27'b0, wb_rd}, 32'd5);
    drive(1'b1, OP_LBU, 32'h103, 32'h0, 5'd6);
    tick();
    check("lbu_wb_data", wb_data, 32'h00000088);
    check("lbu_wb_rd", {27'b0, wb_rd}, 32'd6);
    drive(1'b1, OP_LH, 32'h102, 32'h0, 5'd7);
    @(negedge clk);
    check("lh_stall", {31'b0, stall_out}, 32'h0);
    tick();
    check("lh_wb_data", wb_data, 32'hFFFF8899);
    drive(1'b1, OP_LHU, 32'h100, 32'h0, 5'd0);
    tick();
    check("lhu_wb_data", wb_data, 32'h0000AABB);
    check("lhu_rd0_reg_write", {31'b0, wb_reg_write}, 32'h0);

    // SB 0xCC at 0x101
    drive(1'b1, OP_SB, 32'h101, 32'hFFFFFFCC, 5'd3);
    @(negedge clk);
    check("sb_stall", {31'b0, stall_out}, 32'h1);
    check("sb_rd_phase_write", {31'b0, mem_write}, 32'h0);
    tick();
    check("sb_bubble_wb_valid", {31'b0, wb_valid}, 32'h0);
    @(negedge clk);
    check("sb_write", {31'b0, mem_write}, 32'h1);
    check("sb_write_data", mem_write_data, 32'h8899CCBB);
    check("sb_write_stall", {31'b0, stall_out}, 32'h0);
    tick();
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 5'd0);
    check("sb_wb_valid", {31'b0, wb_valid}, 32'h1);
    check("sb_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    check("sb_mem", mem[32'h100 >> 2], 32'h8899CCBB);
    preload(32'h100, 32'h8899AABB);
    check("nop_wb_valid", {31'b0, wb_valid}, 32'h0);

    // SH 0x1234 at 0x102 then LW 0x100
    drive(1'b1, OP_SH, 32'h102, 32'hFFFF1234, 5'd0);
    @(negedge clk);
    check("sh_stall", {31'b0, stall_out}, 32'h1);
    tick();
    @(negedge clk);
    check("sh_write_data", mem_write_data, 32'h1234AABB);
    tick();
    drive(1'b1, OP_LW, 32'h100, 32'h0, 5'd9);
    check("sh_mem", mem[32'h100 >> 2], 32'h1234AABB);
    tick();
    check("lw_wb_data", wb_data, 32'h1234AABB);
    check("lw_wb_reg_write", {31'b0, wb_reg_write}, 32'h1);
    check("lw_wb_rd", {27'b0, wb_rd}, 32'd9);

    // SW 0xDEADBEEF at 0x200
    drive(1'b1, OP_SW, 32'h200, 32'hDEADBEEF, 5'd4);
    @(negedge clk);
    check("sw_write", {31'b0, mem_write}, 32'h1);
    check("sw_write_data", mem_write_data, 32'hDEADBEEF);
    check("sw_stall", {31'b0, stall_out}, 32'h0);
    tick();
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 5'd0);
    check("sw_wb_valid", {31'b0, wb_valid}, 32'h1);
    check("sw_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    check("sw_mem", mem[32'h200 >> 2], 32'hDEADBEEF);
    @(negedge clk);
    check("sw_write_done", {31'b0, mem_write}, 32'h0);

    // Reset during the WRITE cycle of an SB
    tick();
    preload(32'h100, 32'h8899AABB);
    drive(1'b1, OP_SB, 32'h101, 32'h000000CC, 5'd0);
    tick();
    reset = 1'b1;
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 5'd0);
    #1;
    check("rst_mid_write", {31'b0, mem_write}, 32'h0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("rst2_wb_valid", {31'b0, wb_valid}, 32'h0);
    check("rst2_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    check("rst2_wb_data", wb_data, 32'h0);
    check("rst2_wb_rd", {27'b0, wb_rd}, 32'h0);
    check("rst2_mem", mem[32'h100 >> 2], 32'h8899AABB);
    @(negedge clk);
    check("rst2_idle_write", {31'b0, mem_write}, 32'h0);

    // LW at misaligned 0x102
    tick();
    drive(1'b1, OP_LW, 32'h102, 32'h0, 5'd7);
    tick();
    drive(1'b0, OP_NONE, 32'h0, 32'h0, 5'd0);
    check("mis_wb_valid", {31'b0, wb_valid}, 32'h1);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_wb_reg_write", {31'b0, wb_reg_write}, 32'h0);
    check("mis_exc", {31'b0, misalign_exc}, 32'h1);
    check("mis_addr", misalign_addr, 32'h102);
    tick();
    check("mis_exc_pulse", {31'b0, misalign_exc}, 32'h0);
`else
    check("mis_wb_reg_write", {31'b0, wb_reg_write}, 32'h1);
    check("mis_wb_data", wb_data, 32'h8899AABB);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
